bcd_serial_add_ctrl: RTL and testbench
======================================

BCD_SERIAL_ADD_CTRL -- requirements
Module: bcd_serial_add_ctrl

Interface
REQ-001 Parameter: DIGITS, 4, number of BCD digits per operand (legal range 1..16).
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port: abort  input  1  synchronous cancel of any operation in progress.
REQ-005 Port: in_valid  input  1  operands present on a, b, cin.
REQ-006 Port: in_ready  output  1  controller can accept an operation.
REQ-007 Port: a  input  4*DIGITS  addend A, packed BCD, digit 0 in bits [3:0].
REQ-008 Port: b  input  4*DIGITS  addend B, packed BCD, digit 0 in bits [3:0].
REQ-009 Port: cin  input  1  decimal carry-in to digit 0.
REQ-010 Port: out_valid  output  1  sum, cout and err hold a completed result.
REQ-011 Port: out_ready  input  1  consumer accepts the result.
REQ-012 Port: sum  output  4*DIGITS  packed BCD result.
REQ-013 Port: cout  output  1  decimal carry out of the most significant digit.
REQ-014 Port: err  output  1  at least one operand digit was greater than 9.
REQ-015 Port: busy  output  1  high in RUN state.

Function
REQ-016 The block shall add A+B+cin digit-serially, LSD first, one digit per clock, through a single 4-bit BCD digit adder stage.
REQ-017 The digit stage shall compute s = a_d + b_d + c (5-bit); if s > 9: digit = (s + 6) mod 16, carry = 1; else digit = s, carry = 0; cin is added exactly once.
REQ-018 FSM states shall be IDLE, RUN, DONE; in_ready = 1 only in IDLE; busy = 1 only in RUN; out_valid = 1 only in DONE.
REQ-019 IDLE: on in_valid & in_ready at a rising edge, capture a, b into shift registers, carry register <= cin, digit counter <= 0, err <= (any digit of a or b > 9), go to RUN.
REQ-020 RUN: each edge, process digit 0 of the shift registers, shift A/B right by 4, shift result digit into sum from the MSD end, carry <= stage carry, counter += 1.
REQ-021 RUN shall last exactly DIGITS cycles; on the edge processing digit DIGITS-1, cout <= stage carry and state -> DONE; out_valid is high exactly DIGITS cycles after the accept edge.
REQ-022 DONE: sum, cout, err shall hold stable while out_valid & !out_ready, indefinitely.
REQ-023 DONE: on out_valid & out_ready, go to IDLE; in_ready returns high the following cycle (no same-cycle accept).
REQ-024 in_valid in RUN or DONE shall be ignored and shall not alter internal state.
REQ-025 abort (any state) shall force IDLE on the next edge, clear out_valid, busy, err; sum and cout shall be cleared to 0; abort has priority over the handshake and over DONE acceptance.
REQ-026 Operands with digits > 9 shall still produce the deterministic result defined by REQ-017.
REQ-027 sum and cout shall be driven from registers only (no combinational path from a, b to outputs).

Reset
REQ-028 rst_n low shall immediately force IDLE, sum = 0, cout = 0, err = 0, out_valid = 0, busy = 0, counter = 0, carry = 0, irrespective of the clock.
REQ-029 After rst_n deasserts, in_ready shall be 1 and the first accept may occur on the next rising edge.
REQ-030 rst_n asserted during RUN or DONE shall discard the operation; no out_valid shall follow.

Verification (DIGITS = 4)
REQ-031 a=0x1234, b=0x5678, cin=0, out_ready=1 -> out_valid 4 cycles after accept, sum=0x6912, cout=0, err=0.
REQ-032 a=0x9999, b=0x0001, cin=0 -> sum=0x0000, cout=1; a=0x9999, b=0x9999, cin=1 -> sum=0x9999, cout=1.
REQ-033 a=0x00A0, b=0x0000, cin=0 -> err=1, sum=0x0100, cout=0.
REQ-034 out_ready=0 for 10 cycles after completion, in_valid pulsed meanwhile -> sum/cout/err stable, in_ready=0, no new capture; out_ready=1 -> IDLE next cycle.
REQ-035 rst_n low at RUN digit 2, then abort at RUN digit 1 of a new operation -> all outputs 0, state IDLE, in_ready=1, no out_valid pulse.
REQ-036 Back-to-back operations at maximum throughput -> each result after exactly 4 RUN cycles, one accept per DIGITS+2 cycles, correct carries, no leakage of carry between operations.

Source files
------------

// File: rtl/bcd_serial_add_ctrl.sv
// rtl/bcd_serial_add_ctrl.sv - digit-serial packed-BCD adder with valid/ready handshakes
//
// Adds A + B + cin one BCD digit per clock, least significant digit first,
// through a single 4-bit decimal digit stage.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   abort      synchronous cancel; returns to IDLE and clears the result
//   in_valid   operands present on a, b, cin
//   in_ready   high only in IDLE; an operation is accepted on in_valid & in_ready
//   a, b       packed BCD addends, digit 0 in bits [3:0]
//   cin        decimal carry into digit 0
//   out_valid  high only in DONE; sum, cout, err hold the completed result
//   out_ready  consumer accepts the result
//   sum        packed BCD result (registered)
//   cout       decimal carry out of the most significant digit (registered)
//   err        some operand digit was greater than 9
//   busy       high only in RUN

module bcd_serial_add_ctrl #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  abort,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  cin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  err,
    output logic                  busy
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state;
    logic [W-1:0]    a_sr;
    logic [W-1:0]    b_sr;
    logic            carry;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    sum_r;
    logic            cout_r;
    logic            err_r;
    logic            in_ready_r;
    logic            busy_r;
    logic            out_valid_r;

    // Digit stage: always works on digit 0 of the operand shift registers.
    logic [4:0]      st_raw;
    logic [3:0]      st_digit;
    logic            st_carry;
    logic [W-1:0]    a_shift;
    logic [W-1:0]    b_shift;
    logic [W-1:0]    sum_shift;

    always_comb begin
        st_raw   = {1'b0, a_sr[3:0]} + {1'b0, b_sr[3:0]} + {4'b0000, carry};
        st_digit = st_raw[3:0];
        st_carry = 1'b0;
        if (st_raw > 5'd9) begin
            // Decimal correction; wraps mod 16 for illegal digits as well.
            st_digit = st_raw[3:0] + 4'd6;
            st_carry = 1'b1;
        end
    end

    // Operands shift toward digit 0; result digits enter at the MSD end so that
    // after DIGITS steps the first digit computed sits in bits [3:0].
    always_comb begin
        a_shift              = a_sr >> 4;
        b_shift              = b_sr >> 4;
        sum_shift            = sum_r >> 4;
        sum_shift[W-1 -: 4]  = st_digit;
    end

    function automatic logic has_bad_digit(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            a_sr        <= '0;
            b_sr        <= '0;
            carry       <= 1'b0;
            cnt         <= '0;
            sum_r       <= '0;
            cout_r      <= 1'b0;
            err_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b0;
        end else if (abort) begin
            // Cancel wins over every handshake, including DONE acceptance.
            state       <= S_IDLE;
            a_sr        <= '0;
            b_sr        <= '0;
            carry       <= 1'b0;
            cnt         <= '0;
            sum_r       <= '0;
            cout_r      <= 1'b0;
            err_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_sr       <= a;
                        b_sr       <= b;
                        carry      <= cin;
                        cnt        <= '0;
                        cout_r     <= 1'b0;
                        err_r      <= has_bad_digit(a) | has_bad_digit(b);
                        state      <= S_RUN;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                    end
                end

                S_RUN: begin
                    a_sr  <= a_shift;
                    b_sr  <= b_shift;
                    sum_r <= sum_shift;
                    carry <= st_carry;
                    if (cnt == CNT_LAST) begin
                        // Counter rewinds here so it never needs to hold DIGITS.
                        cnt         <= '0;
                        cout_r      <= st_carry;
                        state       <= S_DONE;
                        busy_r      <= 1'b0;
                        out_valid_r <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                S_DONE: begin
                    // No same-cycle accept: in_ready rises only once back in IDLE.
                    if (out_ready) begin
                        state       <= S_IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        carry       <= 1'b0;
                    end
                end

                default: begin
                    state       <= S_IDLE;
                    in_ready_r  <= 1'b1;
                    busy_r      <= 1'b0;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign busy      = busy_r;
    assign out_valid = out_valid_r;
    assign sum       = sum_r;
    assign cout      = cout_r;
    assign err       = err_r;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// tb/tb_bcd_serial_add_ctrl.sv - self-checking bench for bcd_serial_add_ctrl

module tb_bcd_serial_add_ctrl;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;
    localparam int NVEC   = 11;

    logic          clk;
    logic          rst_n;
    logic          abort;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          cin;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  sum;
    logic          cout;
    logic          err;
    logic          busy;

    int total;
    int bad;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         err;
    } vec_t;

    vec_t vecs [NVEC];

    bcd_serial_add_ctrl #(.DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .err       (err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after the
    // result has been consumed, so back-to-back calls run at full throughput.
    task automatic run_op(input vec_t v, input int idx);
        int lat;
        check($sformatf("v%0d in_ready", idx), in_ready, 1);
        a = v.a; b = v.b; cin = v.cin; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
        check($sformatf("v%0d busy", idx), busy, 1);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check($sformatf("v%0d latency", idx), lat, DIGITS);
        check($sformatf("v%0d sum", idx), sum, v.sum);
        check($sformatf("v%0d cout", idx), cout, v.cout);
        check($sformatf("v%0d err", idx), err, v.err);
        @(negedge clk);
        check($sformatf("v%0d out_valid drop", idx), out_valid, 0);
        check($sformatf("v%0d in_ready back", idx), in_ready, 1);
    endtask

    task automatic wait_out_valid(input string name);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(name, out_valid, 1);
    endtask

    initial begin
        int  seen;
        total = 0;
        bad   = 0;

        vecs[0]  = '{16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0};
        vecs[1]  = '{16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2]  = '{16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0};
        vecs[3]  = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[4]  = '{16'h00A0, 16'h0000, 1'b0, 16'h0100, 1'b0, 1'b1};
        vecs[5]  = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
        vecs[6]  = '{16'h5000, 16'h5000, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[7]  = '{16'h0999, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[8]  = '{16'h4321, 16'h1111, 1'b1, 16'h5433, 1'b0, 1'b0};
        vecs[9]  = '{16'h000F, 16'h0000, 1'b0, 16'h0015, 1'b0, 1'b1};
        vecs[10] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'h5555, 1'b1, 1'b1};

        rst_n = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        repeat (2) @(negedge clk);
        check("rst in_ready", in_ready, 1);
        check("rst out_valid", out_valid, 0);
        check("rst busy", busy, 0);
        check("rst sum", sum, 0);
        check("rst cout", cout, 0);
        check("rst err", err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Back-to-back table at maximum throughput.
        for (int i = 0; i < NVEC; i++) begin
            run_op(vecs[i], i);
        end

        // Consumer stall with in_valid pulsing while DONE.
        a = 16'h1234; b = 16'h5678; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        wait_out_valid("stall reach done");
        for (int k = 0; k < 10; k++) begin
            in_valid = (k % 2 == 0);
            a = 16'h1111; b = 16'h2222; cin = 1'b1;
            @(negedge clk);
            check($sformatf("stall%0d sum", k), sum, 16'h6912);
            check($sformatf("stall%0d cout", k), cout, 0);
            check($sformatf("stall%0d err", k), err, 0);
            check($sformatf("stall%0d out_valid", k), out_valid, 1);
            check($sformatf("stall%0d in_ready", k), in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("stall release out_valid", out_valid, 0);
        check("stall release in_ready", in_ready, 1);

        // Asynchronous reset while processing digit 2.
        a = 16'h1234; b = 16'h5678; cin = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async rst busy", busy, 0);
        check("async rst sum", sum, 0);
        check("async rst in_ready", in_ready, 1);
        check("async rst out_valid", out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post rst in_ready", in_ready, 1);

        // Abort during digit 1 of a fresh operation that has set err.
        a = 16'h00A7; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("abort op err set", err, 1);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort in_ready", in_ready, 1);
        check("abort busy", busy, 0);
        check("abort err", err, 0);
        check("abort sum", sum, 0);
        check("abort cout", cout, 0);
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            if (out_valid) seen++;
            @(negedge clk);
        end
        check("no out_valid after abort/reset", seen, 0);

        // Abort beats DONE acceptance.
        a = 16'h9999; b = 16'h0001; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        wait_out_valid("abort-done reach");
        check("abort-done cout before", cout, 1);
        abort = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort-done out_valid", out_valid, 0);
        check("abort-done cout", cout, 0);
        check("abort-done in_ready", in_ready, 1);

        // Carry must not leak from the aborted operation.
        run_op(vecs[3], 99);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
